// File: rtl/instruction_decode_buffer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | instruction_decode_buffer_pkg                                    |
// | Shared instruction, opcode and decoded-entry types.              |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package instruction_decode_buffer_pkg;

  typedef logic [31:0] instruction_t;

  typedef enum logic [6:0] {
    Lui        = 7'b0110111,
    Auipc      = 7'b0010111,
    Jal        = 7'b1101111,
    Jalr       = 7'b1100111,
    BranchType = 7'b1100011,
    LoadType   = 7'b0000011,
    StoreType  = 7'b0100011,
    UlaIType   = 7'b0010011,
    UlaRType   = 7'b0110011,
    UlaIWType  = 7'b0011011,
    UlaRWType  = 7'b0111011,
    Fence      = 7'b0001111,
    SystemType = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    ImmR = 3'd0,
    ImmI = 3'd1,
    ImmS = 3'd2,
    ImmB = 3'd3,
    ImmU = 3'd4,
    ImmJ = 3'd5
  } imm_format_t;

  // Storage is always 64-bit wide; 32-bit configurations use the low half.
  typedef struct packed {
    opcode_t     opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] imm;
    logic [63:0] pc;
    logic        illegal;
  } decoded_t;

endpackage

`default_nettype wire

// File: rtl/instruction_imm_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | instruction_imm_gen                                              |
// | Combinational immediate generation and legality check.           |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module instruction_imm_gen
  import instruction_decode_buffer_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  instruction_t    instruction,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [6:0]  op;
  imm_format_t format;
  logic        known;
  logic [31:0] imm32;

  assign op = instruction[6:0];

  always_comb begin
    format = ImmR;
    known  = 1'b1;
    case (op)
      UlaIType, UlaIWType, LoadType, Jalr, Fence, SystemType: format = ImmI;
      StoreType:                                              format = ImmS;
      BranchType:                                             format = ImmB;
      Lui, Auipc:                                             format = ImmU;
      Jal:                                                    format = ImmJ;
      UlaRType, UlaRWType:                                    format = ImmR;
      default:                                                known  = 1'b0;
    endcase
  end

  assign illegal = (instruction[1:0] != 2'b11) || !known ||
                   ((XLEN == 32) && ((op == UlaRWType) || (op == UlaIWType)));

  // Every format fits in 32 bits with its sign at bit 31, so widen once at the end.
  always_comb begin
    imm32 = '0;
    if (!illegal) begin
      case (format)
        ImmI: imm32 = {{20{instruction[31]}}, instruction[31:20]};
        ImmS: imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
        ImmB: imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                       instruction[30:25], instruction[11:8], 1'b0};
        ImmU: imm32 = {instruction[31:12], 12'b0};
        ImmJ: imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                       instruction[20], instruction[30:21], 1'b0};
        default: imm32 = '0;
      endcase
    end
  end

  if (XLEN == 64) begin : g_xlen64
    assign imm = {{32{imm32[31]}}, imm32};
  end else begin : g_xlen32
    assign imm = imm32;
  end

endmodule

`default_nettype wire

// File: rtl/instruction_decode_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | instruction_decode_buffer                                        |
// | Decode-at-push FIFO of decoded instruction entries.              |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module instruction_decode_buffer
  import instruction_decode_buffer_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instruction,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output decoded_t                 out_decoded,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  decoded_t         mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             alive;
  logic             push;
  logic             pop;
  decoded_t         entry;
  logic [XLEN-1:0]  imm;
  logic             illegal;

  instruction_imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .instruction (in_instruction),
    .imm         (imm),
    .illegal     (illegal)
  );

  always_comb begin
    entry         = '0;
    entry.opcode  = opcode_t'(in_instruction[6:0]);
    entry.rd      = in_instruction[11:7];
    entry.rs1     = in_instruction[19:15];
    entry.rs2     = in_instruction[24:20];
    entry.funct3  = in_instruction[14:12];
    entry.funct7  = in_instruction[31:25];
    entry.imm     = 64'(imm);
    entry.pc      = 64'(in_pc);
    entry.illegal = illegal;
  end

  // alive holds in_ready low until the first edge after reset release.
  assign in_ready    = alive && (count < CNT_FULL);
  assign out_valid   = (count != '0);
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign out_decoded = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alive  <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      alive <= 1'b1;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= entry;
          wr_ptr      <= wr_ptr + PTR_ONE;
        end
        if (pop) rd_ptr <= rd_ptr + PTR_ONE;
        case ({push, pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instruction_decode_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_instruction_decode_buffer                                     |
// | Randomised + directed bench against a queue-based decode model.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_instruction_decode_buffer;
  import instruction_decode_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instruction;
  logic [63:0] in_pc;
  logic        out_ready;

  logic        in_ready64, out_valid64, in_ready32, out_valid32;
  decoded_t    dec64, dec32;
  logic [2:0]  count64, count32;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] qi[$];
  logic [63:0] qp[$];
  bit          m_alive;

  logic [6:0] op_tab [13] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                              7'h13, 7'h33, 7'h1B, 7'h3B, 7'h0F, 7'h73};

  instruction_decode_buffer #(.XLEN(64), .DEPTH(DEPTH)) dut64 (
    .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready64), .in_instruction(in_instruction), .in_pc(in_pc),
    .out_valid(out_valid64), .out_ready(out_ready), .out_decoded(dec64), .count(count64));

  instruction_decode_buffer #(.XLEN(32), .DEPTH(DEPTH)) dut32 (
    .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready32), .in_instruction(in_instruction), .in_pc(in_pc[31:0]),
    .out_valid(out_valid32), .out_ready(out_ready), .out_decoded(dec32), .count(count32));

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic longint field(logic [31:0] w, int lo, int n);
    return longint'((w >> lo) & ((32'd1 << n) - 32'd1));
  endfunction

  // Reference decode from the ISA field definitions, using signed arithmetic.
  function automatic decoded_t ref_decode(logic [31:0] w, logic [63:0] pc, int xlen);
    decoded_t d;
    longint   sw;
    longint   v;
    bit       ok;
    sw = longint'($signed(w));
    ok = 1'b0;
    foreach (op_tab[i]) if (op_tab[i] == w[6:0]) ok = 1'b1;
    if (xlen == 32 && (w[6:0] == 7'h3B || w[6:0] == 7'h1B)) ok = 1'b0;
    if (w[1:0] != 2'b11) ok = 1'b0;
    case (w[6:0])
      7'h13, 7'h1B, 7'h03, 7'h67, 7'h0F, 7'h73: v = sw >>> 20;
      7'h23: v = (sw >>> 25) * 32 + field(w, 7, 5);
      7'h63: v = (sw >>> 31) * 4096 + field(w, 7, 1) * 2048 + field(w, 25, 6) * 32 + field(w, 8, 4) * 2;
      7'h37, 7'h17: v = (sw >>> 12) * 4096;
      7'h6F: v = (sw >>> 31) * 1048576 + field(w, 12, 8) * 4096 + field(w, 20, 1) * 2048 + field(w, 21, 10) * 2;
      default: v = 0;
    endcase
    d         = '0;
    d.opcode  = opcode_t'(w[6:0]);
    d.rd      = w[11:7];
    d.rs1     = w[19:15];
    d.rs2     = w[24:20];
    d.funct3  = w[14:12];
    d.funct7  = w[31:25];
    d.imm     = ok ? 64'(v) : 64'd0;
    d.pc      = pc;
    d.illegal = !ok;
    return d;
  endfunction

  task automatic compare_all(input string tag);
    decoded_t    e;
    logic [63:0] m32;
    m32 = 64'h0000_0000_FFFF_FFFF;
    check({tag, " count"}, 64'(count64), 64'(qi.size()));
    check({tag, " count32"}, 64'(count32), 64'(qi.size()));
    check({tag, " in_ready"}, 64'(in_ready64), 64'(m_alive && qi.size() < DEPTH));
    check({tag, " out_valid"}, 64'(out_valid64), 64'(qi.size() != 0));
    check({tag, " hs32"}, 64'({in_ready32, out_valid32}), 64'({in_ready64, out_valid64}));
    if (qi.size() != 0) begin
      e = ref_decode(qi[0], qp[0], 64);
      check({tag, " fields64"}, 64'({dec64.opcode, dec64.rd, dec64.rs1, dec64.rs2, dec64.funct3, dec64.funct7}),
            64'({e.opcode, e.rd, e.rs1, e.rs2, e.funct3, e.funct7}));
      check({tag, " imm64"}, dec64.imm, e.imm);
      check({tag, " pc64"}, dec64.pc, e.pc);
      check({tag, " illegal64"}, 64'(dec64.illegal), 64'(e.illegal));
      e = ref_decode(qi[0], qp[0], 32);
      check({tag, " fields32"}, 64'({dec32.opcode, dec32.rd, dec32.rs1, dec32.rs2, dec32.funct3, dec32.funct7}),
            64'({e.opcode, e.rd, e.rs1, e.rs2, e.funct3, e.funct7}));
      check({tag, " imm32"}, dec32.imm & m32, e.imm & m32);
      check({tag, " pc32"}, dec32.pc & m32, e.pc & m32);
      check({tag, " illegal32"}, 64'(dec32.illegal), 64'(e.illegal));
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] w, input logic [63:0] pc, input bit rdy, input bit fl);
    in_valid = v; in_instruction = w; in_pc = pc; out_ready = rdy; flush = fl;
  endtask

  // One clock: predict the handshake from pre-edge state, advance the model, compare.
  task automatic cycle(input string tag);
    bit push, pop;
    push = in_valid && m_alive && (qi.size() < DEPTH);
    pop  = out_ready && (qi.size() != 0);
    @(posedge clock);
    #1;
    m_alive = 1'b1;
    if (flush) begin
      qi.delete(); qp.delete();
    end else begin
      if (pop) begin
        void'(qi.pop_front()); void'(qp.pop_front());
      end
      if (push) begin
        qi.push_back(in_instruction); qp.push_back(in_pc);
      end
    end
    compare_all(tag);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 3) == 0) return r;
    return {r[31:7], op_tab[$urandom_range(0, 12)]};
  endfunction

  initial begin
    m_alive = 1'b0;
    reset_n = 1'b0;
    drive(0, 32'h0, 64'h0, 0, 0);
    #2;
    check("rst count", 64'(count64), 64'd0);
    check("rst in_ready", 64'(in_ready64), 64'd0);
    check("rst out_valid", 64'(out_valid64), 64'd0);
    check("rst out_decoded", 64'(|dec64), 64'd0);
    #1 reset_n = 1'b1;
    #1 check("rst release in_ready", 64'(in_ready64), 64'd0);
    cycle("boot");

    drive(1, 32'hFFF00093, 64'h1000, 0, 0);
    cycle("addi");
    check("addi out_valid", 64'(out_valid64), 64'd1);
    check("addi opcode", 64'(dec64.opcode), 64'h13);
    check("addi rd", 64'(dec64.rd), 64'd1);
    check("addi rs1", 64'(dec64.rs1), 64'd0);
    check("addi imm", dec64.imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addi illegal", 64'(dec64.illegal), 64'd0);
    drive(0, 32'h0, 64'h0, 1, 0);
    cycle("addi drain");

    drive(1, 32'hFE000EE3, 64'h2000, 0, 0);
    cycle("beq");
    check("beq imm", dec64.imm, 64'hFFFF_FFFF_FFFF_FFFC);
    check("beq funct3", 64'(dec64.funct3), 64'd0);
    drive(1, 32'h800002B7, 64'h2004, 1, 0);
    cycle("lui");
    check("lui rd", 64'(dec64.rd), 64'd5);
    check("lui imm", dec64.imm, 64'hFFFF_FFFF_8000_0000);
    check("lui count", 64'(count64), 64'd1);
    drive(0, 32'h0, 64'h0, 1, 0);
    cycle("lui drain");

    drive(1, 32'h002081BB, 64'h3000, 0, 0);
    cycle("addw");
    check("addw illegal32", 64'(dec32.illegal), 64'd1);
    check("addw imm32", dec32.imm & 64'hFFFF_FFFF, 64'd0);
    check("addw illegal64", 64'(dec64.illegal), 64'd0);
    drive(1, 32'h0, 64'h3004, 1, 0);
    cycle("zero");
    check("zero illegal32", 64'(dec32.illegal), 64'd1);
    check("zero illegal64", 64'(dec64.illegal), 64'd1);
    drive(0, 32'h0, 64'h0, 1, 0);
    cycle("zero drain");

    for (int k = 0; k < 5; k++) begin
      drive(1, 32'h0000_0013 | (k << 7), 64'h4000 + 64'(k) * 4, 0, 0);
      cycle("fill");
      if (k >= 3) begin
        check("full in_ready", 64'(in_ready64), 64'd0);
        check("full count", 64'(count64), 64'd4);
      end
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("order pc", dec64.pc, 64'h4000 + 64'(k) * 4);
      cycle("drain");
      in_valid = 1'b0;
    end
    check("drained", 64'(count64), 64'd0);

    drive(1, 32'h00100093, 64'h5000, 0, 0);
    cycle("pre-flush");
    cycle("pre-flush");
    drive(1, 32'h00200093, 64'h5008, 1, 1);
    cycle("flush");
    check("flush count", 64'(count64), 64'd0);
    check("flush out_valid", 64'(out_valid64), 64'd0);

    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 1), rand_inst(), {$urandom, $urandom},
            $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
      cycle("rand");
    end

    drive(0, 32'h0, 64'h0, 1, 0);
    for (int k = 0; k < DEPTH; k++) cycle("pre-reset drain");
    for (int k = 0; k < 3; k++) begin
      drive(1, rand_inst(), 64'h6000 + 64'(k) * 4, 0, 0);
      cycle("pre-reset fill");
    end
    drive(0, 32'h0, 64'h0, 0, 0);
    check("pre-reset count", 64'(count64), 64'd3);
    #1 reset_n = 1'b0;
    #1;
    check("async rst count", 64'(count64), 64'd0);
    check("async rst out_valid", 64'(out_valid64), 64'd0);
    check("async rst in_ready", 64'(in_ready64), 64'd0);
    check("async rst out_decoded", 64'(|dec64), 64'd0);
    qi.delete(); qp.delete();
    m_alive = 1'b0;
    #1 reset_n = 1'b1;
    cycle("re-boot");
    check("re-boot in_ready", 64'(in_ready64), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instruction_decode_buffer.md
INSTRUCTION_DECODE_BUFFER -- requirements
Module: instruction_decode_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width; legal values are 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 4, number of decoded-entry slots; must be a power of two, at least 2.
REQ-003 SHALL have port clock, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port flush, input, 1 bit, discard all buffered entries.
REQ-006 SHALL have port in_valid, input, 1 bit, upstream instruction present.
REQ-007 SHALL have port in_ready, output, 1 bit, buffer can accept.
REQ-008 SHALL have port in_instruction, input, 32 bits, raw instruction word.
REQ-009 SHALL have port in_pc, input, XLEN bits, instruction address.
REQ-010 SHALL have port out_valid, output, 1 bit, head entry valid.
REQ-011 SHALL have port out_ready, input, 1 bit, downstream consumes head.
REQ-012 SHALL have port out_decoded, output, decoded_t, head entry: opcode, rd, rs1, rs2, funct3, funct7, imm[XLEN-1:0], pc, illegal.
REQ-013 SHALL have port count, output, $clog2(DEPTH)+1 bits, occupied slots.

Function
REQ-014 SHALL accept an instruction on a cycle where in_valid and in_ready are both 1 (push).
REQ-015 SHALL pop the head on a cycle where out_valid and out_ready are both 1.
REQ-016 SHALL drive in_ready = (count < DEPTH); a full buffer does not accept, even when a pop occurs in the same cycle.
REQ-017 SHALL drive out_valid = (count != 0); there is no combinational bypass, so a push appears at the output one cycle later at the earliest.
REQ-018 SHALL decode at push time and store the decoded result, so out_decoded is a register output.
REQ-019 SHALL extract rd = inst[11:7], rs1 = inst[19:15], rs2 = inst[24:20], funct3 = inst[14:12] and funct7 = inst[31:25] for every format.
REQ-020 SHALL form imm as follows, sign-extended from the top bit to XLEN:
- I-format (UlaIType, UlaIWType, LoadType, Jalr, Fence, SystemType): inst[31:20].
- S-format: {inst[31:25], inst[11:7]}.
- B-format: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
- U-format (Lui, Auipc): {inst[31:12], 12'b0}.
- J-format: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- R-format: 0.
REQ-021 SHALL set illegal = 1 when any of the following holds:
- inst[1:0] != 2'b11;
- the opcode is not in opcode_t;
- XLEN == 32 and the opcode is UlaRWType or UlaIWType.
REQ-022 SHALL still store an illegal entry in order, with imm = 0.
REQ-023 SHALL keep pc unchanged, stored alongside its decode.
REQ-024 SHALL on a simultaneous push and pop (count between 1 and DEPTH-1) leave count unchanged and advance both pointers.
REQ-025 SHALL wrap the read and write pointers modulo DEPTH.
REQ-026 SHALL on flush = 1 set count to 0 and equalize both pointers at the next edge; flush overrides any same-cycle push or pop, and the pushed word is dropped.
REQ-027 SHALL hold out_decoded stable while out_valid = 1 and out_ready = 0.

Reset
REQ-028 SHALL, while reset_n = 0, force count = 0, pointers = 0, out_valid = 0, in_ready = 0 and out_decoded = all-zero, asynchronously.
REQ-029 SHALL take in_ready to 1 on the first clock edge after reset_n rises; any entries present when reset asserts mid-operation are lost.

Structure
REQ-030 SHALL define decoded_t and imm_format_t (R, I, S, B, U, J) in the shared instruction package; decoded_t is parametrised via XLEN = 64 storage, and users truncate for 32-bit.
REQ-031 SHALL implement immediate generation in combinational sub-module instruction_imm_gen (inputs instruction_t and XLEN; outputs imm and illegal), instantiated once on the push path.

Verification
REQ-032 SHALL cover: XLEN=64, push 0xFFF00093 -> next cycle out_valid = 1, opcode UlaIType, rd = 1, rs1 = 0, imm = 0xFFFFFFFFFFFFFFFF, illegal = 0.
REQ-033 SHALL cover: push 0xFE000EE3 (beq x0,x0,-4) -> imm = -4, funct3 = 0; then push 0x800002B7 -> rd = 5, imm = 0xFFFFFFFF80000000.
REQ-034 SHALL cover: XLEN=32, push 0x002081BB (addw) -> illegal = 1, imm = 0; push 0x00000000 -> illegal = 1.
REQ-035 SHALL cover: DEPTH=4, out_ready = 0, push 5 words back-to-back -> in_ready = 0 after the 4th, the 5th word is not taken, count = 4; assert out_ready -> the words exit in order.
REQ-036 SHALL cover: count = 2, then assert flush together with a push and a pop -> next cycle count = 0 and out_valid = 0.
REQ-037 SHALL cover: reset_n asserted with count = 3 -> count = 0 and out_valid = 0 immediately, without waiting for a clock edge.
